// File: rtl/ram_2p_bwe_clr_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM.
// Imported by the interface, clear controller and top level.
package ram_pkg;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    function automatic int num_lanes(input int dw, input int bw);
        return dw / bw;
    endfunction

    function automatic bit lanes_ok(input int dw, input int bw);
        return (bw > 0) && (dw % bw == 0);
    endfunction

endpackage

// File: rtl/ram_2p_bwe_clr_if.sv
// Write/read/clear bus of the byte-enable dual-port RAM.
// The master drives requests; the slave is the RAM.
interface ram_2p_bwe_clr_if
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int BYTE_WIDTH = 8
);
    localparam int NL = num_lanes(DATA_WIDTH, BYTE_WIDTH);

    logic [DATA_WIDTH-1:0] Data_in;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic                  WEN;
    logic [NL-1:0]         BEN;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic                  REN;
    logic                  CLR_REQ;
    logic [DATA_WIDTH-1:0] Data_out;
    logic                  Out_valid;
    logic                  BUSY;

    modport master (
        output Data_in, write_addr, WEN, BEN,
        output read_addr, REN, CLR_REQ,
        input  Data_out, Out_valid, BUSY
    );

    modport slave (
        input  Data_in, write_addr, WEN, BEN,
        input  read_addr, REN, CLR_REQ,
        output Data_out, Out_valid, BUSY
    );

endinterface

// File: rtl/ram_2p_bwe_clr_clear_ctrl.sv
// Clear sweep controller: walks every address once, then returns
// to IDLE. Drives the clear side of the array write mux.
module ram_clear_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH   = 4,
    parameter bit CLR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLR_ON_RESET ? CLEAR : IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    addr_d  = '0;
                end
            end
            CLEAR: begin
                // counter wraps to 0 on the last address
                addr_d = addr_q + ADDR_WIDTH'(1);
                if (addr_q == '1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase
    end

    assign busy     = (state_q == CLEAR);
    assign clr_we   = (state_q == CLEAR);
    assign clr_addr = addr_q;

endmodule

// File: rtl/ram_2p_bwe_clr.sv
// Simple-dual-port RAM with byte enables, write-first read bypass
// and a sweep clear engine. Storage has no reset.
module ram_2p_bwe_clr
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int BYTE_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] CLR_VALUE = '0,
    parameter bit CLR_ON_RESET = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    ram_2p_bwe_clr_if.slave  bus
);

    localparam int NL    = num_lanes(DATA_WIDTH, BYTE_WIDTH);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (!lanes_ok(DATA_WIDTH, BYTE_WIDTH)) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  busy;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  user_ok;
    logic                  user_we;
    logic                  user_re;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NL-1:0]         lane_we;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  valid_q;

    ram_clear_ctrl #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .CLR_ON_RESET (CLR_ON_RESET)
    ) u_clr (
        .clk      (CLK),
        .rst      (RST),
        .clr_req  (bus.CLR_REQ),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // a clear request in IDLE wins over same-cycle user traffic
    assign user_ok = !busy && !bus.CLR_REQ;
    assign user_we = user_ok && bus.WEN;
    assign user_re = user_ok && bus.REN;

    always_comb begin
        wr_addr = bus.write_addr;
        wr_data = bus.Data_in;
        lane_we = '0;
        if (clr_we) begin
            wr_addr = clr_addr;
            wr_data = CLR_VALUE;
            lane_we = '1;
        end else if (user_we) begin
            lane_we = bus.BEN;
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < NL; i++) begin
            if (lane_we[i]) begin
                mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                    wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // write-first bypass, lane by lane
    always_comb begin
        rd_word = mem[bus.read_addr];
        for (int i = 0; i < NL; i++) begin
            if (user_we && bus.BEN[i] &&
                bus.write_addr == bus.read_addr) begin
                rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] =
                    bus.Data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= user_re;
            if (user_re) begin
                dout_q <= rd_word;
            end
        end
    end

    assign bus.Data_out  = dout_q;
    assign bus.Out_valid = valid_q;
    assign bus.BUSY      = busy;

endmodule

// File: doc/ram_2p_bwe_clr.md
# ram_2p_bwe_clr

Parametrised single-clock simple-dual-port RAM (one write port, one read port) with per-byte write enables, a registered read port with write-first collision bypass, and a sequential clear engine. The clear engine sweeps the whole array after reset or on request. It is the storage element for the next-generation FIFOs and buffers. The array has no per-word reset, so it maps onto block RAM, and it is still initialised to a known value before first use.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits; must be an integer multiple of BYTE_WIDTH
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words
- BYTE_WIDTH, 8, bits per write-enable lane
- CLR_VALUE, 0, word value written by the clear engine (DATA_WIDTH bits)
- CLR_ON_RESET, 1, 1 = start a clear sweep when RST is released; 0 = no clear on reset (BUSY resets to 0)

Ports:
- CLK  input  1  clock; all state changes on the rising edge
- RST  input  1  asynchronous, active-high reset
- Data_in  input  DATA_WIDTH  write data
- write_addr  input  ADDR_WIDTH  write address
- WEN  input  1  write request
- BEN  input  DATA_WIDTH/BYTE_WIDTH  byte-lane enables; lane i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH]
- read_addr  input  ADDR_WIDTH  read address
- REN  input  1  read request
- CLR_REQ  input  1  single-cycle pulse requesting a full clear sweep
- Data_out  output  DATA_WIDTH  registered read data
- Out_valid  output  1  high for one cycle when Data_out carries the result of a read
- BUSY  output  1  clear sweep in progress; WEN, REN and CLR_REQ are ignored while high

## Operation
- Controller FSM has two states, IDLE and CLEAR, with an ADDR_WIDTH-bit sweep counter clr_addr.
- Reset (RST=1): state = CLEAR if CLR_ON_RESET else IDLE. clr_addr = 0. Data_out = 0. Out_valid = 0. BUSY = CLR_ON_RESET. The array contents are not touched by reset.
- CLEAR:
  - Each cycle writes CLR_VALUE to all lanes at clr_addr, then increments clr_addr.
  - After the write to DEPTH-1, the FSM goes to IDLE and clr_addr wraps to 0.
  - User WEN, REN and CLR_REQ are ignored. Out_valid = 0. Data_out holds its value.
- IDLE with CLR_REQ=1: enters CLEAR. A WEN or REN in the same cycle is dropped. CLR_REQ has priority.
- IDLE with WEN=1: for each lane with BEN[i]=1, that lane of RAM[write_addr] takes the matching lane of Data_in. Other lanes are unchanged. WEN with BEN=0 is a no-op.
- IDLE with REN=1: Data_out is loaded from RAM[read_addr] and Out_valid=1 for the following cycle.
- IDLE with REN=0: Out_valid=0 and Data_out holds its last value.
- Collision (REN and WEN in the same cycle, read_addr == write_addr): write-first, resolved per lane.
  - Lanes with BEN[i]=1 return Data_in.
  - Other lanes return the old content.
- Different addresses in the same cycle: independent operation, with no interaction.
- RST asserted mid-sweep: the sweep aborts immediately. If CLR_ON_RESET=1, it restarts from address 0 after release.

## Timing
- Write: takes effect at the sampling edge. A read of the same address one cycle later returns the new data.
- Read latency: 1 cycle. REN sampled at edge N; Data_out and Out_valid are valid from edge N until edge N+1.
- Clear duration:
  - BUSY rises at the edge that samples CLR_REQ.
  - BUSY falls exactly DEPTH cycles later.
  - First user access is accepted at the edge where BUSY is sampled 0.
- Reset release with CLR_ON_RESET=1: the first rising edge after release writes address 0. BUSY deasserts after DEPTH edges.
- Full throughput: one write and one read per cycle in IDLE. No wait states.

## Structure
- Package ram_pkg:
  - state enum {IDLE, CLEAR}
  - helper function num_lanes(DATA_WIDTH, BYTE_WIDTH)
  - elaboration check that DATA_WIDTH % BYTE_WIDTH == 0
- Sub-module ram_clear_ctrl: FSM, sweep counter, BUSY. It outputs clr_we and clr_addr to the array write mux.
- Top level contains:
  - the array, with no reset on the storage
  - the write-port mux: clear vs. user
  - per-lane write enables
  - the registered read with collision bypass

## Test plan
- Reset, CLR_VALUE=0xA5A5A5A5, DEPTH=16:
  - BUSY=1 for exactly 16 cycles after release.
  - Then read all addresses; each returns 0xA5A5A5A5 with Out_valid pulsing.
- Write 0x11223344 to address 3 with BEN=4'b1111, then write 0xFFFFFFFF with BEN=4'b0101 -> read of address 3 returns 0x11FF33FF.
- Same cycle: WEN to address 7, data 0xDEADBEEF, BEN=4'b0011, old content 0x01020304; REN to address 7 -> Data_out=0x0102BEEF next cycle.
- Same cycle: CLR_REQ with WEN to address 2 and REN -> write dropped, Out_valid stays 0, BUSY high for 16 cycles, address 2 reads CLR_VALUE afterwards.
- WEN/REN/CLR_REQ asserted while BUSY -> no array change, Out_valid=0, sweep length unchanged.
- RST pulse at sweep address 9 -> outputs return to reset values, sweep restarts at address 0, BUSY low 16 cycles after release.
